// File: rtl/tetris_pkg.sv
// tetris_pkg: shared playfield geometry, coordinate widths and line-clear state encoding
package tetris_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int X_W = 4;
  localparam int Y_W = 5;
  localparam logic [BOARD_W-1:0] FULL_ROW = 10'h3FF;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/board_line_clear.sv
// board_line_clear: scan FSM (bottom-up row index, shift enable, cleared-row counter, busy/done)
module board_line_clear
  import tetris_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           clear_start,
  input  logic           clear_all,
  input  logic           row_full,
  output logic [Y_W-1:0] r,
  output logic           shift,
  output logic           clear_busy,
  output logic           clear_done,
  output logic [4:0]     lines_cleared
);
  logic [1:0] state;
  assign shift = (state == S_SCAN) && row_full;
  assign clear_busy = state == S_SCAN;
  assign clear_done = state == S_DONE;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      r <= '0;
      lines_cleared <= '0;
    end else if (clear_all) begin
      state <= S_IDLE;
      lines_cleared <= '0;
    end else if (state == S_IDLE) begin
      if (clear_start) begin
        state <= S_SCAN;
        r <= Y_W'(BOARD_H - 1);
        lines_cleared <= '0;
      end
    end else if (state == S_SCAN) begin
      if (row_full) lines_cleared <= lines_cleared + 5'd1;
      else if (r == '0) state <= S_DONE;
      else r <= r - Y_W'(1);
    end else
      state <= S_IDLE;
endmodule

// File: rtl/board_mem.sv
// board_mem: 10x20 occupancy store; comb logic read/write port, registered VGA read, line-clear engine
module board_mem #(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [tetris_pkg::X_W-1:0] board_rx,
  input  logic [tetris_pkg::Y_W-1:0] board_ry,
  output logic                      board_rdata,
  input  logic                      board_we,
  input  logic [tetris_pkg::X_W-1:0] board_wx,
  input  logic [tetris_pkg::Y_W-1:0] board_wy,
  input  logic                      board_wdata,
  input  logic [tetris_pkg::X_W-1:0] vga_x,
  input  logic [tetris_pkg::Y_W-1:0] vga_y,
  output logic                      vga_rdata,
  input  logic                      clear_start,
  input  logic                      clear_all,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [4:0]                lines_cleared
);
  import tetris_pkg::*;
  logic [BOARD_W-1:0] rows [BOARD_H];
  logic [BOARD_W-1:0] above [BOARD_H];
  logic [Y_W-1:0] r;
  logic shift;
  logic wr_ok;
  board_line_clear u_clear (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .clear_start(clear_start),
    .clear_all(clear_all),
    .row_full(rows[r] == FULL_ROW),
    .r(r),
    .shift(shift),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .lines_cleared(lines_cleared)
  );
  assign board_rdata = (int'(board_rx) >= BOARD_W || int'(board_ry) >= BOARD_H) ? 1'b1 : rows[board_ry][board_rx];
  assign wr_ok = board_we && !clear_busy && int'(board_wx) < BOARD_W && int'(board_wy) < BOARD_H;
  always_comb begin
    above[0] = '0;
    for (int k = 1; k < BOARD_H; k++) above[k] = rows[k-1];
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) for (int k = 0; k < BOARD_H; k++) rows[k] <= '0;
    else if (clear_all) for (int k = 0; k < BOARD_H; k++) rows[k] <= '0;
    else if (shift) begin
      for (int k = 0; k < BOARD_H; k++) if (k <= int'(r)) rows[k] <= above[k];
    end else if (wr_ok) rows[board_wy][board_wx] <= board_wdata;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) vga_rdata <= 1'b0;
    else vga_rdata <= (int'(vga_x) < BOARD_W && int'(vga_y) < BOARD_H) ? rows[vga_y][vga_x] : 1'b0;
endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: randomized self-checking bench for board_mem against a row-collapse reference model
module tb_board_mem;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [3:0] board_rx = '0, board_wx = '0, vga_x = '0;
  logic [4:0] board_ry = '0, board_wy = '0, vga_y = '0;
  logic board_we = 1'b0, board_wdata = 1'b0, clear_start = 1'b0, clear_all = 1'b0;
  logic board_rdata, vga_rdata, clear_busy, clear_done;
  logic [4:0] lines_cleared;
  always #5 CLOCK_50 = ~CLOCK_50;
  board_mem dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
    .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rdata(vga_rdata),
    .clear_start(clear_start), .clear_all(clear_all),
    .clear_busy(clear_busy), .clear_done(clear_done), .lines_cleared(lines_cleared)
  );
  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  bit [9:0] mb [20];
  bit [9:0] res [20];
  int phase = 0, left = 0, mn = 0, mlines = 0;
  logic vga_exp = 1'b0;
  bit vga_valid = 1'b0, armed = 1'b0;
  function automatic logic mrd(input int x, input int y);
    return (x >= 10 || y >= 20) ? 1'b1 : logic'(mb[y][x]);
  endfunction
  task automatic collapse();
    int d = 19;
    mn = 0;
    for (int y = 0; y < 20; y++) res[y] = '0;
    for (int y = 19; y >= 0; y--)
      if (mb[y] == 10'h3FF) mn++;
      else begin
        res[d] = mb[y];
        d--;
      end
  endtask
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int y = 0; y < 20; y++) mb[y] = '0;
      phase = 0;
      mlines = 0;
      vga_exp = 1'b0;
      vga_valid = 1'b1;
    end else begin
      vga_valid = phase != 1;
      vga_exp = (vga_x < 10 && vga_y < 20) ? logic'(mb[vga_y][vga_x]) : 1'b0;
      if (clear_all) begin
        for (int y = 0; y < 20; y++) mb[y] = '0;
        phase = 0;
        mlines = 0;
      end else if (phase == 1) begin
        left--;
        if (left == 0) begin
          mb = res;
          mlines = mn;
          phase = 2;
        end
      end else begin
        if (board_we && board_wx < 10 && board_wy < 20) mb[board_wy][board_wx] = board_wdata;
        if (phase == 0 && clear_start) begin
          collapse();
          left = 20 + mn;
          phase = 1;
        end else phase = 0;
      end
    end
  end
  always @(negedge CLOCK_50)
    if (armed && !reset) begin
      chk("busy", 32'(clear_busy), 32'(phase == 1));
      chk("done", 32'(clear_done), 32'(phase == 2));
      if (phase != 1) begin
        chk("lines", 32'(lines_cleared), 32'(mlines));
        chk("rdata", 32'(board_rdata), 32'(mrd(int'(board_rx), int'(board_ry))));
      end
      if (vga_valid) chk("vga", 32'(vga_rdata), 32'(vga_exp));
    end
  task automatic tick();
    @(posedge CLOCK_50);
    #2;
    board_we = 1'b0;
    clear_start = 1'b0;
    clear_all = 1'b0;
  endtask
  task automatic wr(input int x, input int y, input logic d);
    board_wx = 4'(x);
    board_wy = 5'(y);
    board_wdata = d;
    board_we = 1'b1;
    tick();
  endtask
  task automatic rd(input int x, input int y);
    board_rx = 4'(x);
    board_ry = 5'(y);
    #1;
  endtask
  task automatic wait_scan(output int n);
    n = 0;
    while (clear_busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("scan_timeout", 32'(clear_busy), 32'd0);
  endtask
  initial begin
    int n;
    logic acc;
    repeat (2) @(posedge CLOCK_50);
    #2;
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_lines", 32'(lines_cleared), 0);
    chk("rst_vga", 32'(vga_rdata), 0);
    acc = 1'b0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        board_rx = 4'(x); board_ry = 5'(y); vga_x = 4'(x); vga_y = 5'(y);
        #1 acc |= board_rdata;
        tick();
        acc |= vga_rdata;
      end
    chk("all_zero", 32'(acc), 0);
    rd(10, 5);
    chk("oor_x_logic", 32'(board_rdata), 1);
    rd(3, 20);
    chk("oor_y_logic", 32'(board_rdata), 1);
    vga_x = 4'd10; vga_y = 5'd5;
    tick();
    chk("oor_x_vga", 32'(vga_rdata), 0);
    vga_x = 4'd3; vga_y = 5'd20;
    tick();
    chk("oor_y_vga", 32'(vga_rdata), 0);
    wr(4, 19, 1'b1);
    rd(4, 19);
    chk("wr_visible", 32'(board_rdata), 1);
    vga_x = 4'd4; vga_y = 5'd19;
    tick();
    chk("wr_vga", 32'(vga_rdata), 1);
    wr(12, 3, 1'b1);
    for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
    wr(2, 18, 1'b1);
    clear_start = 1'b1;
    tick();
    wait_scan(n);
    chk("scan1_cycles", 32'(n), 21);
    chk("scan1_done", 32'(clear_done), 1);
    chk("scan1_lines", 32'(lines_cleared), 1);
    rd(2, 19);
    chk("scan1_cell", 32'(board_rdata), 1);
    acc = 1'b0;
    for (int x = 0; x < 10; x++) begin rd(x, 18); acc |= board_rdata; end
    chk("scan1_row18", 32'(acc), 0);
    for (int y = 16; y < 20; y++) for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
    wr(0, 15, 1'b1);
    clear_start = 1'b1;
    tick();
    wait_scan(n);
    chk("scan4_cycles", 32'(n), 24);
    chk("scan4_lines", 32'(lines_cleared), 4);
    rd(0, 19);
    chk("scan4_cell", 32'(board_rdata), 1);
    rd(2, 19);
    chk("scan4_gone", 32'(board_rdata), 0);
    for (int x = 1; x < 10; x++) wr(x, 19, 1'b1);
    clear_start = 1'b1;
    tick();
    tick();
    tick();
    board_wx = 4'd5; board_wy = 5'd5; board_wdata = 1'b1; board_we = 1'b1; clear_start = 1'b1;
    tick();
    wait_scan(n);
    chk("midscan_cycles", 32'(n + 3), 21);
    chk("midscan_lines", 32'(lines_cleared), 1);
    rd(5, 5);
    chk("midscan_wr_ignored", 32'(board_rdata), 0);
    wr(3, 19, 1'b1);
    wr(3, 18, 1'b1);
    clear_start = 1'b1;
    tick();
    repeat (4) tick();
    clear_all = 1'b1;
    tick();
    chk("clrall_busy", 32'(clear_busy), 0);
    rd(3, 19);
    chk("clrall_cell", 32'(board_rdata), 0);
    acc = 1'b0;
    repeat (25) begin tick(); acc |= clear_done; end
    chk("clrall_nodone", 32'(acc), 0);
    wr(6, 19, 1'b1);
    wr(0, 19, 1'b1);
    vga_x = 4'd6; vga_y = 5'd19;
    tick();
    clear_start = 1'b1;
    tick();
    tick();
    tick();
    rd(6, 19);
    reset = 1'b1;
    #1;
    chk("areset_busy", 32'(clear_busy), 0);
    chk("areset_done", 32'(clear_done), 0);
    chk("areset_lines", 32'(lines_cleared), 0);
    chk("areset_vga", 32'(vga_rdata), 0);
    chk("areset_cell", 32'(board_rdata), 0);
    #1 reset = 1'b0;
    clear_start = 1'b1;
    tick();
    wait_scan(n);
    chk("empty_cycles", 32'(n), 20);
    chk("empty_done", 32'(clear_done), 1);
    chk("empty_lines", 32'(lines_cleared), 0);
    for (int i = 0; i < 3000; i++) begin
      board_rx = 4'($urandom_range(0, 15));
      board_ry = 5'($urandom_range(0, 22));
      vga_x = 4'($urandom_range(0, 11));
      vga_y = 5'($urandom_range(0, 21));
      board_we = ($urandom_range(0, 99) < 60);
      board_wx = 4'($urandom_range(0, 11));
      board_wy = 5'($urandom_range(12, 20));
      board_wdata = ($urandom_range(0, 99) < 85);
      clear_start = ($urandom_range(0, 99) < 3);
      clear_all = ($urandom_range(0, 999) < 3);
      tick();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/board_mem.md
# board_mem

Occupancy storage for the 10×20 Tetris playfield; the responder side of the board read/write interface driven by `gamelogic`. It gives gamelogic a same-cycle combinational read port for collision checks and a single-cycle write port for locking pieces. It also gives the VGA renderer a registered read port, and contains a line-clear engine that finds full rows, removes them and collapses the board downward.

## Interface
Parameters:
- `BOARD_W`, default 10: columns (x = 0..9, left to right)
- `BOARD_H`, default 20: rows (y = 0..19, y = 0 is the top row)

Ports:
- `CLOCK_50`  in  1: sole clock, rising edge
- `reset`  in  1: asynchronous, active-high; clears everything
- `board_rx`  in  4: logic read column
- `board_ry`  in  5: logic read row
- `board_rdata`  out  1: combinational occupancy of (rx, ry); 1 when rx > 9 or ry > 19 (out of range reads as a wall)
- `board_we`  in  1: write strobe, one cycle
- `board_wx`  in  4: write column
- `board_wy`  in  5: write row
- `board_wdata`  in  1: value written
- `vga_x`  in  4: renderer read column
- `vga_y`  in  5: renderer read row
- `vga_rdata`  out  1: registered occupancy; 0 when out of range
- `clear_start`  in  1: one-cycle request to run the line clear
- `clear_all`  in  1: one-cycle request to zero the board (new game)
- `clear_busy`  out  1: high while the scan runs
- `clear_done`  out  1: one-cycle pulse when the scan is finished
- `lines_cleared`  out  5: number of rows removed by the last scan (0..20)

## Operation
- Storage: 20 row registers of 10 bits; bit x of row y is cell (x, y).
- Write:
  - On a rising edge with `board_we` = 1 and in-range coordinates, `row[wy][wx]` <= `wdata`.
  - Out-of-range writes are ignored.
  - Writes are ignored while `clear_busy` = 1.
- Line-clear FSM states: `S_IDLE`, `S_SCAN`, `S_DONE`.
  - `S_IDLE`: when `clear_start` = 1, set r <= 19, `lines_cleared` <= 0, go to `S_SCAN`.
  - `S_SCAN`, row r is full (`row[r]` == 10'h3FF):
    - Shift in one cycle: `row[k]` <= `row[k-1]` for k = r..1, and `row[0]` <= 0.
    - `lines_cleared` += 1.
    - Stay in `S_SCAN` with r unchanged, so the row that moved down is tested again.
  - `S_SCAN`, row r is not full: if r == 0 go to `S_DONE`, otherwise r <= r − 1.
  - `S_DONE`: assert `clear_done` for one cycle, then go to `S_IDLE`.
- `clear_start` is ignored outside `S_IDLE`.
- `clear_all` has the highest priority in any state:
  - zero all rows, set the FSM to `S_IDLE` and `lines_cleared` to 0;
  - no `clear_done` pulse is produced.
- Termination: a shift at r = 0 loads zeros into row 0, so the scan always ends.

## Timing
- Reset values: all rows 0; `vga_rdata` 0; `clear_busy` 0; `clear_done` 0; `lines_cleared` 0; FSM in `S_IDLE`.
- `board_rdata`:
  - zero latency from address to data;
  - a write becomes visible in the cycle after its edge.
- `vga_rdata`: one-cycle latency; it samples the array as it stands before the same edge's write.
- Line-clear latency:
  - `clear_start` is sampled at edge E0.
  - `clear_busy` = 1 from E0 until the edge that enters `S_DONE`.
  - `S_SCAN` lasts 20 + N cycles, where N is the number of cleared rows.
  - `clear_done` is high for 1 cycle with `clear_busy` = 0.
  - `lines_cleared` is final when `clear_done` is high and holds until the next accepted start.
- Simultaneous `board_we` and `clear_start` in `S_IDLE`: the write commits on the same edge, so the scan sees the written cell.
- `board_rdata` during a scan reflects the partially shifted array; the client must not read while busy.
- Reset mid-scan: the board is zeroed immediately and asynchronously, with no done pulse.

## Structure
- Shared package `tetris_pkg`:
  - `BOARD_W`, `BOARD_H`;
  - `X_W` = 4, `Y_W` = 5;
  - `FULL_ROW` = 10'h3FF;
  - the line-clear state encoding, which `gamelogic`'s `S_CLEAR` handshake also uses.
- One sub-module, `board_line_clear`, holds the FSM, the row index r and the counter. It outputs a shift-enable and r to the top. The storage array, ports and shift datapath stay in `board_mem`.

## Test plan
- Reset, then read all 200 cells on both ports → all 0. Read (10, 5) and (3, 20) on the logic port → `board_rdata` = 1; on the VGA port → 0.
- Write (4, 19) = 1 → `board_rdata` at (4, 19) is 1 the next cycle; `vga_rdata` is 1 one cycle after the address is presented. A write to (12, 3) changes nothing.
- Fill row 19 fully, put one cell at (2, 18), pulse `clear_start` → busy for 21 scan cycles, `lines_cleared` = 1, cell (2, 19) = 1, row 18 all 0.
- Fill rows 16–19 fully, with (0, 15) set → busy for 24 scan cycles, `lines_cleared` = 4, only (0, 19) remains set.
- Pulse `board_we` and a second `clear_start` mid-scan → both ignored. Assert `clear_all` mid-scan → board all 0, `clear_busy` drops next cycle, no `clear_done`.
- Assert `reset` mid-scan → all outputs return to 0 asynchronously. A following `clear_start` on an empty board → `clear_done` after 20 scan cycles with `lines_cleared` = 0.
